rca_seq_adder_ctrl: RTL and testbench

//   Sequencer that time-multiplexes one 8-bit ripple-carry adder (rca_8bit) to add

---
 rtl/rca_seq_pkg.sv | 21 ++
 rtl/rca_8bit.sv | 23 ++
 rtl/rca_seq_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_rca_seq_adder_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the byte-serial ripple-carry adder sequencer.
package rca_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte counter width: $clog2(words), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module rca_8bit
  import rca_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_cout
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[BYTE_W];

endmodule

// File: rtl/rca_seq_adder_ctrl.sv
// Byte-serial WORDS*8-bit adder: one rca_8bit reused LSB byte first, carry registered.
// Optional macro RCA_SEQ_SUB_EN adds a 'sub' input selecting A-B.
module rca_seq_adder_ctrl
  import rca_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*8-1:0]    a_in,
  input  logic [WORDS*8-1:0]    b_in,
  input  logic                  cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*8-1:0]    sum_out,
  output logic                  cout_out,
  output logic                  ovf_out,
  output logic                  busy
);

  localparam int unsigned W     = WORDS * BYTE_W;
  localparam int unsigned CNT_W = cnt_width(WORDS);

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_sub;
  logic               r_cout;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic               w_sub_in;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_s;
  logic               w_co;
  logic               w_last;
  logic               w_ovf;

`ifdef RCA_SEQ_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + 1; the +1 comes from forcing the initial carry.
  assign w_b_byte = r_b[BYTE_W-1:0] ^ {BYTE_W{r_sub}};
  assign w_last   = (r_cnt == CNT_W'(WORDS - 1));
  assign w_ovf    = signed_ovf(r_a[BYTE_W-1], w_b_byte[BYTE_W-1], w_s[BYTE_W-1]);

  rca_8bit u_rca (
    .i_a    (r_a[BYTE_W-1:0]),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_sub      <= w_sub_in;
            r_carry    <= w_sub_in ? 1'b1 : cin;
            r_cnt      <= '0;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_sum[i*BYTE_W +: BYTE_W] <= w_s;
            end
          end
          r_carry <= w_co;
          r_a     <= r_a >> BYTE_W;
          r_b     <= r_b >> BYTE_W;
          if (w_last) begin
            r_cout      <= w_co;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum_out   = r_sum;
  assign cout_out  = r_cout;
  assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Self-checking bench for rca_seq_adder_ctrl (WORDS=4 and WORDS=1 instances).
module tb_rca_seq_adder_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = WORDS * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum_out;
  logic          cout_out;
  logic          ovf_out;
  logic          busy;
`ifdef RCA_SEQ_SUB_EN
  logic          sub_in = 1'b0;
  logic          sub1 = 1'b0;
`endif

  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [7:0]    a1 = '0;
  logic [7:0]    b1 = '0;
  logic          cin1 = 1'b0;
  logic          out_valid1;
  logic          out_ready1 = 1'b1;
  logic [7:0]    sum1;
  logic          cout1;
  logic          ovf1;
  logic          busy1;

  int checks = 0;
  int errors = 0;

  rca_seq_adder_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .cout_out(cout_out), .ovf_out(ovf_out), .busy(busy)
  );

  rca_seq_adder_ctrl #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a1), .b_in(b1), .cin(cin1),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum_out(sum1),
    .cout_out(cout1), .ovf_out(ovf1), .busy(busy1)
  );

  // Reference: full-width arithmetic; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    logic         ov;
    bb   = sb ? ~b : b;
    c    = sb ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one operand set, wait (bounded) for out_valid, return what the DUT shows.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, output int lat, output logic [W-1:0] s,
                        output logic co, output logic ov);
    a_in = a; b_in = b; cin = ci;
`ifdef RCA_SEQ_SUB_EN
    sub_in = sb;
`else
    if (sb) $display("note: sub requested without RCA_SEQ_SUB_EN");
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    s = sum_out; co = cout_out; ov = ovf_out;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, busy, sum_out, cout_out, ovf_out} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset4 got rdy=%b ov=%b busy=%b sum=%h co=%b ovf=%b exp 1 0 0 0 0 0",
               in_ready, out_valid, busy, sum_out, cout_out, ovf_out);
    end
    checks++;
    if ({in_ready1, out_valid1, busy1, sum1, cout1, ovf1} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset1 got rdy=%b ov=%b busy=%b sum=%h co=%b ovf=%b exp 1 0 0 0 0 0",
               in_ready1, out_valid1, busy1, sum1, cout1, ovf1);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    logic [W-1:0] tb [5] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000, 32'h00000000};
    logic         tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] es [5] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
    logic         eco[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         eov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [W-1:0] s; logic co, ov;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], 1'b0, lat, s, co, ov);
      checks++;
      if ({s, co, ov} !== {es[i], eco[i], eov[i]}) begin
        errors++;
        $display("FAIL dir%0d got sum=%h co=%b ovf=%b exp sum=%h co=%b ovf=%b",
                 i, s, co, ov, es[i], eco[i], eov[i]);
      end
      checks++;
      if (lat !== WORDS) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, WORDS);
      end
      step();
    end
  endtask

  task automatic test_handshake();
    a_in = 32'h12345678; b_in = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL run_flags got busy=%b rdy=%b ov=%b exp 1 0 0", busy, in_ready, out_valid);
    end
    repeat (WORDS) step();
    checks++;
    if ({out_valid, busy, sum_out} !== {1'b1, 1'b1, 32'h23456789}) begin
      errors++;
      $display("FAIL done_flags got ov=%b busy=%b sum=%h exp 1 1 23456789", out_valid, busy, sum_out);
    end
    step();
    checks++;
    if ({out_valid, busy, in_ready, sum_out} !== {1'b0, 1'b0, 1'b1, 32'h23456789}) begin
      errors++;
      $display("FAIL idle_hold got ov=%b busy=%b rdy=%b sum=%h exp 0 0 1 23456789",
               out_valid, busy, in_ready, sum_out);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] s; logic co, ov; logic [W+1:0] exp;
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    exp = ref_add(a, b, 1'b1, 1'b0);
    out_ready = 1'b0;
    run_op(a, b, 1'b1, 1'b0, lat, s, co, ov);
    checks++;
    if ({ov, co, s} !== exp) begin
      errors++;
      $display("FAIL bp_result got %h exp %h", {ov, co, s}, exp);
    end
    for (int i = 0; i < 5; i++) begin
      a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
      step();
      checks++;
      if ({out_valid, in_ready, ovf_out, cout_out, sum_out} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b rdy=%b res=%h exp 1 0 %h",
                 i, out_valid, in_ready, {ovf_out, cout_out, sum_out}, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, busy, ovf_out, cout_out, sum_out} !== {1'b1, 1'b0, 1'b0, exp}) begin
      errors++;
      $display("FAIL bp_release got rdy=%b ov=%b busy=%b res=%h exp 1 0 0 %h",
               in_ready, out_valid, busy, {ovf_out, cout_out, sum_out}, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W-1:0] s; logic co, ov; logic [W+1:0] exp;
    logic seen;
    a_in = 32'hDEADBEEF; b_in = 32'h01020304; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, sum_out, cout_out, ovf_out} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst got rdy=%b ov=%b busy=%b sum=%h co=%b ovf=%b exp 1 0 0 0 0 0",
               in_ready, out_valid, busy, sum_out, cout_out, ovf_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result got out_valid seen=%b exp 0", seen);
    end
    exp = ref_add(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0);
    run_op(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, lat, s, co, ov);
    checks++;
    if ({ov, co, s, lat} !== {exp, WORDS}) begin
      errors++;
      $display("FAIL midrst_fresh got res=%h lat=%0d exp res=%h lat=%0d", {ov, co, s}, lat, exp, WORDS);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] s; logic co, ov; logic [W+1:0] exp;
    logic [W-1:0] a, b; logic c;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      if (i % 7 == 0) a = {1'b0, {(W-1){1'b1}}};
      if (i % 11 == 0) b = {1'b1, {(W-1){1'b0}}};
      exp = ref_add(a, b, c, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_ready got %b exp 1", i, in_ready);
      end
      run_op(a, b, c, 1'b0, lat, s, co, ov);
      checks++;
      if ({ov, co, s} !== exp || lat != WORDS) begin
        errors++;
        $display("FAIL b2b%0d a=%h b=%h c=%b got res=%h lat=%0d exp res=%h lat=%0d",
                 i, a, b, c, {ov, co, s}, lat, exp, WORDS);
      end
      step();
    end
  endtask

  task automatic test_words1();
    int lat; logic [8:0] full; logic eov;
    logic [7:0] ta [4] = '{8'h7F, 8'hFF, 8'h80, 8'h3C};
    logic [7:0] tb [4] = '{8'h01, 8'h01, 8'hFF, 8'h42};
    logic       tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        a1 = ta[i]; b1 = tb[i]; cin1 = tc[i];
      end else begin
        a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom_range(0, 1));
      end
      full = {1'b0, a1} + {1'b0, b1} + {8'h00, cin1};
      eov  = (a1[7] == b1[7]) && (full[7] != a1[7]);
      in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 40) begin
        step();
        lat++;
      end
      checks++;
      if ({eov, full} !== {ovf1, cout1, sum1} || lat != 1) begin
        errors++;
        $display("FAIL w1_%0d a=%h b=%h got res=%h lat=%0d exp res=%h lat=1",
                 i, a1, b1, {ovf1, cout1, sum1}, lat, {eov, full});
      end
      step();
    end
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub();
    int lat; logic [W-1:0] s; logic co, ov; logic [W+1:0] exp;
    logic [W-1:0] a, b;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, lat, s, co, ov);
    checks++;
    if ({co, s} !== {1'b0, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL sub_5m7 got co=%b sum=%h exp 0 fffffffe", co, s);
    end
    step();
    run_op(32'd7, 32'd5, 1'b0, 1'b1, lat, s, co, ov);
    checks++;
    if ({co, s} !== {1'b1, 32'h00000002}) begin
      errors++;
      $display("FAIL sub_7m5 got co=%b sum=%h exp 1 00000002", co, s);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      exp = ref_add(a, b, 1'b0, 1'b1);
      run_op(a, b, 1'($urandom_range(0, 1)), 1'b1, lat, s, co, ov);
      checks++;
      if ({ov, co, s} !== exp) begin
        errors++;
        $display("FAIL sub_rand%0d a=%h b=%h got %h exp %h", i, a, b, {ov, co, s}, exp);
      end
      step();
    end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_directed();
    test_handshake();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_words1();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
